// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage.
//   Drives the data-memory request/grant/rvalid bus for loads and stores.
//   Aligns and extends load data and registers the MEM/WB boundary.
//   Stalls upstream while a transaction is outstanding (one in flight max).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_i..mem2rf_i         EX/MEM inputs (held stable while stall_o)
//   stall_o                   combinational hold request to upstream
//   dmem_*_o / dmem_*_i       data-memory bus (request side is combinational)
//   valid_o..alu_result_o     registered MEM/WB outputs
//   misalign_o, bus_err_o     registered one-cycle fault pulses
module mem_access_stage #(
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        rf_we_i,
  input  logic [31:0] rf_waddr_i,
  input  logic        mem2rf_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic        rf_we_o,
  output logic [31:0] rf_waddr_o,
  output logic        mem2rf_o,
  output logic [31:0] mem_rdata_o,
  output logic [31:0] alu_result_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] RVALID = 2'd2;

  localparam logic                 TO_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q;

  logic        mem_op, misaligned, mem_ok;
  logic        completing, abort, timeout_hit;
  logic [1:0]  byte_off;
  logic [31:0] rdata_shift, rdata_ext;

  // Request decode and alignment check
  assign byte_off   = alu_result_i[1:0];
  assign mem_op     = valid_i & (mem_re_i | mem_we_i);
  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      case (mem_size_i)
        2'd0:    misaligned = 1'b0;
        2'd1:    misaligned = byte_off[0];
        default: misaligned = (byte_off != 2'b00);
      endcase
    end
  end
  assign mem_ok      = mem_op & ~misaligned;
  assign timeout_hit = TO_EN & (cnt_q == TO_LAST);

  // Next-state and bus-handshake decode
  always_comb begin
    state_d    = state_q;
    dmem_req_o = 1'b0;
    completing = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ok) begin
          dmem_req_o = 1'b1;
          if (dmem_gnt_i) begin
            if (mem_we_i) completing = 1'b1;
            else          state_d    = RVALID;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) begin
          if (mem_we_i) begin
            completing = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = RVALID;
          end
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RVALID: begin
        if (dmem_rvalid_i) begin
          completing = 1'b1;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_o = mem_ok & ~completing & ~abort;

  // Bus payload: word-aligned address, lane enables, lane-replicated data
  assign dmem_we_o   = dmem_req_o & mem_we_i;
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = mem_wdata_i;
    case (mem_size_i)
      2'd0: begin
        dmem_be_o    = 4'b0001 << byte_off;
        dmem_wdata_o = {4{mem_wdata_i[7:0]}};
      end
      2'd1: begin
        dmem_be_o    = 4'b0011 << byte_off;
        dmem_wdata_o = {2{mem_wdata_i[15:0]}};
      end
      default: begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = mem_wdata_i;
      end
    endcase
  end

  // Load alignment and sign/zero extension
  assign rdata_shift = dmem_rdata_i >> {byte_off, 3'b000};
  always_comb begin
    rdata_ext = rdata_shift;
    case (mem_size_i)
      2'd0: rdata_ext = mem_unsigned_i ? {24'd0, rdata_shift[7:0]}
                                       : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      2'd1: rdata_ext = mem_unsigned_i ? {16'd0, rdata_shift[15:0]}
                                       : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: rdata_ext = rdata_shift;
    endcase
  end

  // State register and timeout counter (cleared whenever the state changes)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == REQ || state_q == RVALID)
        cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  // MEM/WB register; a stall inserts a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o      <= 1'b0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      mem2rf_o     <= 1'b0;
      mem_rdata_o  <= '0;
      alu_result_o <= '0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else if (stall_o) begin
      valid_o    <= 1'b0;
      rf_we_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      valid_o      <= valid_i;
      rf_we_o      <= rf_we_i & ~misaligned & ~abort;
      rf_waddr_o   <= rf_waddr_i;
      mem2rf_o     <= mem2rf_i;
      alu_result_o <= alu_result_i;
      mem_rdata_o  <= (valid_i & mem_re_i & ~misaligned & ~abort) ? rdata_ext : 32'd0;
      misalign_o   <= misaligned;
      bus_err_o    <= abort;
    end
  end

endmodule
